serial_shifter: RTL and testbench

- Multi-cycle, area-reduced shift/rotate unit: processes one bit position per clock using a single 1-bit shift stage, as the sequential counterpart of the combinational barrel shifter.
- Adds the right-rotate direction (ROR) alongside SLL/SRA/SRL so the execute stage can offload rotate-right and variable shifts.
- Sits beside the ALU in EX; the pipeline stalls on busy and captures the result on done.

---
 rtl/serial_shifter_if.sv | 25 ++
 rtl/serial_shifter.sv | 125 ++++++++++++
 tb/tb_serial_shifter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_shifter_if.sv
// Request/result bundle for serial_shifter: operand, amount and op in; busy, done and result out.
// The requester uses the master modport; the shifter uses the slave modport.
interface serial_shifter_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic [CNT_W-1:0] bit_cnt;
  logic [1:0]       Op;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Out;

  modport master (
    output start, in, bit_cnt, Op, abort,
    input  busy, done, Out
  );

  modport slave (
    input  start, in, bit_cnt, Op, abort,
    output busy, done, Out
  );
endinterface

// File: rtl/serial_shifter.sv
// Multi-cycle shift/rotate unit (ROR/SLL/SRA/SRL) using one 1-bit shift stage per clock.
// Optional macro SERIAL_SHIFTER_DUAL_STEP_EN: apply two 1-bit steps per SHIFT cycle.
module serial_shifter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_shifter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_ROR = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] d, input op_e op);
    logic [WIDTH-1:0] r;
    unique case (op)
      OP_ROR:  r = {d[0], d[WIDTH-1:1]};
      OP_SLL:  r = {d[WIDTH-2:0], 1'b0};
      OP_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      default: r = {1'b0, d[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  // NOTE: every variable gets its hold/default value before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The cycle carrying a done pulse still belongs to the finished operation.
        if (bus.start && !done_q) begin
          data_d  = bus.in;
          cnt_d   = bus.bit_cnt;
          op_d    = op_e'(bus.Op);
          state_d = (bus.bit_cnt == '0) ? FINISH : SHIFT;
        end
      end

      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
`ifdef SERIAL_SHIFTER_DUAL_STEP_EN
          if (cnt_q >= CNT_W'(2)) begin
            data_d = step1(step1(data_q, op_q), op_q);
            cnt_d  = cnt_q - CNT_W'(2);
          end else begin
            data_d = step1(data_q, op_q);
            cnt_d  = cnt_q - CNT_W'(1);
          end
`else
          data_d = step1(data_q, op_q);
          cnt_d  = cnt_q - CNT_W'(1);
`endif
          if (cnt_d == '0) begin
            state_d = FINISH;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
        if (!bus.abort) begin
          out_d  = data_q;
          done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ROR;
      data_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Out  = out_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Directed self-checking bench for serial_shifter; expected values are hand-computed.
// Build with +define+SERIAL_SHIFTER_DUAL_STEP_EN to exercise the dual-step latency.
module tb_serial_shifter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  serial_shifter_if #(.WIDTH(16), .CNT_W(4)) bus ();

  serial_shifter #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input int n);
`ifdef SERIAL_SHIFTER_DUAL_STEP_EN
    return (n + 1) / 2 + 1;
`else
    return n + 1;
`endif
  endfunction

  // Issues one request, returns the result captured with done, the edge count
  // from acceptance to done and the number of busy samples. Returns after the done cycle.
  task automatic run_op(input logic [15:0] a, input logic [3:0] n, input logic [1:0] op,
                        output logic [15:0] res, output int lat, output int busy_cycles,
                        output bit to);
    @(negedge clk);
    bus.in = a; bus.bit_cnt = n; bus.Op = op; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in = 16'hDEAD; bus.bit_cnt = 4'hF; bus.Op = 2'b01;
    lat = 0; busy_cycles = bus.busy ? 1 : 0; to = 1'b1; res = bus.Out;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        to = 1'b0;
        res = bus.Out;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_op(input string name, input logic [15:0] a, input logic [3:0] n,
                          input logic [1:0] op, input logic [15:0] exp);
    logic [15:0] res;
    int lat, bc;
    bit to;
    run_op(a, n, op, res, lat, bc, to);
    checks++;
    if (to) begin errors++; $display("FAIL %s timeout: no done within budget", name); end
    checks++;
    if (res !== exp) begin errors++; $display("FAIL %s Out: got %h expected %h", name, res, exp); end
    checks++;
    if (lat !== lat_of(n)) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, lat_of(n)); end
    checks++;
    if (bc !== lat_of(n)) begin errors++; $display("FAIL %s busy cycles: got %0d expected %0d", name, bc, lat_of(n)); end
    checks++;
    if (bus.done !== 1'b0 || bus.Out !== exp) begin
      errors++; $display("FAIL %s hold: done=%b Out=%h expected done=0 Out=%h", name, bus.done, bus.Out, exp);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.in = '0; bus.bit_cnt = '0; bus.Op = '0;
    #12;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Out !== 16'h0000) begin
      errors++; $display("FAIL reset: busy=%b done=%b Out=%h expected 0 0 0000", bus.busy, bus.done, bus.Out);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_ror();
    check_op("ror4", 16'h8001, 4'd4, 2'b00, 16'h1800);
    check_op("ror5", 16'h8001, 4'd5, 2'b00, 16'h0C00);
  endtask

  task automatic test_sra_srl();
    check_op("sra4", 16'hF0F0, 4'd4, 2'b10, 16'hFF0F);
    check_op("srl4", 16'hF0F0, 4'd4, 2'b11, 16'h0F0F);
  endtask

  task automatic test_sll();
    check_op("sll15", 16'h0001, 4'd15, 2'b01, 16'h8000);
    check_op("sll0", 16'h0001, 4'd0, 2'b01, 16'h0001);
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    @(negedge clk);
    bus.in = 16'hF0F0; bus.bit_cnt = 4'd2; bus.Op = 2'b11; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.in = 16'hFFFF;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || bus.Out !== 16'h3C3C) begin
      errors++; $display("FAIL b2b first: done_seen=%b Out=%h expected 1 3c3c", seen, bus.Out);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.Out !== 16'h3C3C) begin
      errors++; $display("FAIL b2b done-cycle start: busy=%b Out=%h expected 0 3c3c", bus.busy, bus.Out);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b accept after done: busy=%b expected 1", bus.busy); end
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || bus.Out !== 16'h3FFF) begin
      errors++; $display("FAIL b2b second: done_seen=%b Out=%h expected 1 3fff", seen, bus.Out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    check_op("pre_abort", 16'h00FF, 4'd4, 2'b01, 16'h0FF0);
    @(negedge clk);
    bus.in = 16'hF0F0; bus.bit_cnt = 4'd8; bus.Op = 2'b11; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk); bus.abort = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Out !== 16'h0FF0) begin
      errors++; $display("FAIL abort shift: busy=%b done=%b Out=%h expected 0 0 0ff0", bus.busy, bus.done, bus.Out);
    end
    bus.abort = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    checks++;
    if (seen || bus.Out !== 16'h0FF0) begin
      errors++; $display("FAIL abort aftermath: done_seen=%b Out=%h expected 0 0ff0", seen, bus.Out);
    end
    // start and abort together in IDLE: start wins
    @(negedge clk);
    bus.in = 16'h0003; bus.bit_cnt = 4'd1; bus.Op = 2'b01; bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort+start idle: busy=%b expected 1", bus.busy); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || bus.Out !== 16'h0006) begin
      errors++; $display("FAIL abort+start result: done_seen=%b Out=%h expected 1 0006", seen, bus.Out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(negedge clk);
    bus.in = 16'h1234; bus.bit_cnt = 4'd8; bus.Op = 2'b00; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Out !== 16'h0000) begin
      errors++; $display("FAIL reset mid-shift: busy=%b done=%b Out=%h expected 0 0 0000", bus.busy, bus.done, bus.Out);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    checks++;
    if (seen || bus.Out !== 16'h0000) begin
      errors++; $display("FAIL reset release: activity=%b Out=%h expected 0 0000", seen, bus.Out);
    end
  endtask

  initial begin
    test_reset();
    test_ror();
    test_sra_srl();
    test_sll();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
